// File: rtl/present_pkg.sv
// present_pkg: shared definitions for the serial PRESENT substitution layer.
//   - SBOX_FWD / SBOX_INV : 16x4 forward and inverse S-box tables
//   - fsm_state_e         : controller state encoding (IDLE/RUN/DONE)
//   - nbeats()            : cycles needed to substitute one full state
package present_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  // Packed tables: element [n] is S(n). The literals are written from entry 15
  // down to entry 0 because packed concatenation places the first item highest.
  localparam logic [15:0][3:0] SBOX_FWD = {
    4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
    4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
  };

  localparam logic [15:0][3:0] SBOX_INV = {
    4'hA, 4'h9, 4'h7, 4'h0, 4'h3, 4'h6, 4'h4, 4'hB,
    4'hD, 4'h2, 4'h1, 4'hC, 4'h8, 4'hF, 4'hE, 4'h5
  };

  // Number of beats to walk every nibble of the state through the lanes.
  function automatic int nbeats(input int state_w, input int lanes);
    return state_w / (4 * lanes);
  endfunction

endpackage

// File: rtl/present_sbox_dual.sv
// present_sbox_dual: one combinational PRESENT S-box lane.
//   inv_i : 1 = inverse S-box, 0 = forward S-box
//   nib_i : 4-bit input nibble
//   nib_o : 4-bit substituted nibble
// When inv_i is tied to a constant 0 the inverse table is optimised away.
module present_sbox_dual
  import present_pkg::*;
(
  input  logic       inv_i,
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = inv_i ? SBOX_INV[nib_i] : SBOX_FWD[nib_i];

endmodule

// File: rtl/present_sbox_layer_serial.sv
// present_sbox_layer_serial: area-scalable PRESENT substitution layer.
// A STATE_W-bit state is loaded into a shift register and LANES nibbles are
// substituted per cycle; after STATE_W/(4*LANES) beats every nibble has been
// substituted and rotated back to its original position.
// Ports:
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     : input handshake, in_data + in_inv taken on transfer
//   out_valid/out_ready   : output handshake, out_data held while stalled
//   busy                  : high while a state is in RUN or DONE
//   dbg_state             : current controller state (fsm_state_e encoding)
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready; the producer keeps valid and data stable until that edge,
// and ready never depends combinationally on valid.
module present_sbox_layer_serial
  import present_pkg::*;
#(
  parameter int STATE_W = 64,
  parameter int LANES   = 4,
  parameter int INV_EN  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int NBEATS = nbeats(STATE_W, LANES);
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int LW     = 4 * LANES;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  if ((STATE_W % 4) != 0) begin : g_bad_width
    $error("STATE_W must be a multiple of 4");
  end
  if (((STATE_W / 4) % LANES) != 0) begin : g_bad_lanes
    $error("LANES must divide the number of nibbles in STATE_W");
  end

  fsm_state_e         state_q, state_d;
  logic [STATE_W-1:0] sreg_q, sreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               inv_q, inv_d;
  logic               out_valid_q, out_valid_d;

  logic               inv_eff;
  logic [LW-1:0]      sub_w;
  logic [STATE_W-1:0] shifted_w;

  // With the inverse disabled the lanes see a constant 0 select.
  assign inv_eff = (INV_EN != 0) ? inv_q : 1'b0;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    present_sbox_dual u_sbox (
      .inv_i (inv_eff),
      .nib_i (sreg_q[4*g +: 4]),
      .nib_o (sub_w[4*g +: 4])
    );
  end

  // Substituted nibbles re-enter at the top so that after NBEATS beats each
  // nibble is back at its original index.
  if (LW < STATE_W) begin : g_shift
    assign shifted_w = {sub_w, sreg_q[STATE_W-1:LW]};
  end else begin : g_noshift
    assign shifted_w = sub_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    inv_d       = inv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sreg_d  = in_data;
          inv_d   = (INV_EN != 0) ? in_inv : 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sreg_d = shifted_w;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BEAT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // out_valid is registered: it follows the state being entered.
    out_valid_d = (state_d == ST_DONE);
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = sreg_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_present_sbox_layer_serial.sv
module tb_present_sbox_layer_serial;

  localparam int NI = 6;

  function automatic int lanes_of(input int k);
    case (k)
      0: return 4;
      1: return 1;
      2: return 2;
      3: return 8;
      4: return 16;
      default: return 4;
    endcase
  endfunction

  function automatic int inv_en_of(input int k);
    return (k == 5) ? 0 : 1;
  endfunction

  function automatic int nbeats_of(input int k);
    return 16 / lanes_of(k);
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- DUT instances ----------------
  logic [NI-1:0]        iv, ir, ov, orr, bz;
  logic [NI-1:0][63:0]  od;
  logic [NI-1:0][1:0]   ds;
  logic [63:0]          in_data;
  logic                 in_inv;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    present_sbox_layer_serial #(
      .STATE_W (64),
      .LANES   (lanes_of(g)),
      .INV_EN  (inv_en_of(g))
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_data   (in_data),
      .in_inv    (in_inv),
      .out_valid (ov[g]),
      .out_ready (orr[g]),
      .out_data  (od[g]),
      .busy      (bz[g]),
      .dbg_state (ds[g])
    );
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each nibble independently through a 16-entry table.
  logic [3:0] fwd_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [3:0] inv_t [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                             4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

  function automatic logic [63:0] model(input logic [63:0] d, input logic inv);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = inv ? inv_t[d[4*i +: 4]] : fwd_t[d[4*i +: 4]];
    end
    return r;
  endfunction

  // Scoreboard: one expected queue and accept-edge queue per instance.
  logic [63:0] exp_q [NI][$];
  int          acc_q [NI][$];
  logic [63:0] last_out [NI];
  logic [NI-1:0]       prev_ov, prev_or;
  logic [NI-1:0][63:0] prev_od;

  initial begin
    prev_ov = '0;
    prev_or = '0;
    prev_od = '0;
    for (int k = 0; k < NI; k++) last_out[k] = '0;
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        exp_q[k].delete();
        acc_q[k].delete();
        prev_ov[k] = 1'b0;
        prev_or[k] = 1'b0;
      end else begin
        if (ov[k] && !prev_ov[k]) begin
          if (acc_q[k].size() == 0) begin
            check($sformatf("spurious_out_valid[%0d]", k), 64'(ov[k]), 64'd0);
          end else begin
            check($sformatf("latency[%0d]", k), 64'(edge_cnt - acc_q[k][0]),
                  64'(nbeats_of(k)));
          end
        end
        if (prev_ov[k] && !prev_or[k]) begin
          check($sformatf("stall_valid[%0d]", k), 64'(ov[k]), 64'd1);
          check($sformatf("stall_data[%0d]", k), od[k], prev_od[k]);
        end
        if (ov[k]) begin
          check($sformatf("in_ready_in_done[%0d]", k), 64'(ir[k]), 64'd0);
        end
        if (ov[k] && orr[k] && exp_q[k].size() > 0) begin
          check($sformatf("out_data[%0d]", k), od[k], exp_q[k][0]);
          last_out[k] = od[k];
          void'(exp_q[k].pop_front());
          void'(acc_q[k].pop_front());
        end
        if (iv[k] && ir[k]) begin
          exp_q[k].push_back(model(in_data, in_inv && (inv_en_of(k) != 0)));
          acc_q[k].push_back(edge_cnt + 1);
        end
        prev_ov[k] = ov[k];
        prev_or[k] = orr[k];
        prev_od[k] = od[k];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int k, input logic [63:0] d, input logic inv);
    int n;
    n = 0;
    in_data = d;
    in_inv  = inv;
    iv[k]   = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!ir[k] && n < 100);
    if (!ir[k]) check($sformatf("accept_timeout[%0d]", k), 64'd0, 64'd1);
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((exp_q[k].size() != 0 || ov[k]) && n < 100);
    if (exp_q[k].size() != 0 || ov[k]) check($sformatf("drain_timeout[%0d]", k), 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s_in_ready[%0d]", tag, k), 64'(ir[k]), 64'd1);
      check($sformatf("%s_out_valid[%0d]", tag, k), 64'(ov[k]), 64'd0);
      check($sformatf("%s_busy[%0d]", tag, k), 64'(bz[k]), 64'd0);
      check($sformatf("%s_out_data[%0d]", tag, k), od[k], 64'd0);
      check($sformatf("%s_state[%0d]", tag, k), 64'(ds[k]), 64'd0);
    end
  endtask

  localparam logic [63:0] VEC  = 64'h0123456789ABCDEF;
  localparam logic [63:0] VECF = 64'hC56B90AD3EF84712;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    iv = '0;
    orr = '1;
    in_data = '0;
    in_inv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pin the model to hand-computed values.
    check("model_zero", model(64'h0, 1'b0), 64'hCCCCCCCCCCCCCCCC);
    check("model_vec_fwd", model(VEC, 1'b0), VECF);
    check("model_vec_inv", model(VECF, 1'b1), VEC);
    check("model_ones", model(64'hFFFFFFFFFFFFFFFF, 1'b0), 64'h2222222222222222);

    // Zero state, then vector forward and back through the inverse.
    send(0, 64'h0, 1'b0);
    drain(0);
    check("zero_lit", last_out[0], 64'hCCCCCCCCCCCCCCCC);
    send(0, VEC, 1'b0);
    drain(0);
    check("vec_fwd_lit", last_out[0], VECF);
    send(0, VECF, 1'b1);
    drain(0);
    check("vec_inv_lit", last_out[0], VEC);

    // Lane sweep: same result, latency checked by the scoreboard.
    for (int k = 1; k <= 4; k++) begin
      send(k, VEC, 1'b0);
      drain(k);
      check($sformatf("sweep_lit[%0d]", k), last_out[k], VECF);
    end

    // Backpressure on instance 0.
    orr[0] = 1'b0;
    send(0, VEC, 1'b0);
    n = 0;
    while (!ov[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_reached_done", 64'(ov[0]), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      in_data = 64'hFFFFFFFFFFFFFFFF;
      iv[0] = (c % 2 == 0);
      @(negedge clk);
      check("bp_in_ready", 64'(ir[0]), 64'd0);
      check("bp_out_valid", 64'(ov[0]), 64'd1);
      check("bp_busy", 64'(bz[0]), 64'd1);
      check("bp_out_data", od[0], VECF);
    end
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    orr[0] = 1'b1;
    drain(0);
    check("bp_lit", last_out[0], VECF);
    repeat (6) @(posedge clk);
    #1;
    check("bp_no_extra", 64'(ov[0]), 64'd0);

    // Mid-run reset on beat 2 of 4.
    send(0, VEC, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("midrst_no_out_valid", 64'(ov[0]), 64'd0);
    end
    @(posedge clk);
    #1;
    send(0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    drain(0);
    check("ones_lit", last_out[0], 64'h2222222222222222);

    // Inverse disabled: in_inv must be ignored.
    send(5, 64'h0, 1'b1);
    drain(5);
    check("inv_dis_lit", last_out[5], 64'hCCCCCCCCCCCCCCCC);

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
